// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported SRAM controller.
// One transaction is in flight at a time; the winning request is latched on
// entry to ISSUE and the controller is driven only from those latched copies,
// so requesters may drop or change their inputs mid-transaction.
module sram_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // Requester 0
  input  logic              r0_rd_en_i,
  input  logic              r0_wr_en_i,
  input  logic [ADDR_W-1:0] r0_address_i,
  input  logic [DATA_W-1:0] r0_write_data_i,
  output logic [DATA_W-1:0] r0_read_data_o,
  output logic              r0_ready_o,
  // Requester 1
  input  logic              r1_rd_en_i,
  input  logic              r1_wr_en_i,
  input  logic [ADDR_W-1:0] r1_address_i,
  input  logic [DATA_W-1:0] r1_write_data_i,
  output logic [DATA_W-1:0] r1_read_data_o,
  output logic              r1_ready_o,
  // SRAM controller
  output logic              ctl_rd_en_o,
  output logic              ctl_wr_en_o,
  output logic [ADDR_W-1:0] ctl_address_o,
  output logic [DATA_W-1:0] ctl_write_data_o,
  input  logic [DATA_W-1:0] ctl_read_data_i,
  input  logic              ctl_ready_i,
  // Status
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;          // 0: requester 0 preferred on a tie
  logic [1:0]        owner_q, owner_d;      // one-hot owner of the current transaction
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic req0, req1, win1, active;

  assign req0 = r0_rd_en_i | r0_wr_en_i;
  assign req1 = r1_rd_en_i | r1_wr_en_i;
  // Requester 1 wins when alone, or on a tie when the pointer favours it.
  assign win1 = req1 & (~req0 | ptr_q);

  // Next-state: arbitration and latching in IDLE, completion tracking in WAIT.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          state_d = StIssue;
          ptr_d   = ~win1;
          owner_d = win1 ? 2'b10 : 2'b01;
          op_wr_d = win1 ? r1_wr_en_i : r0_wr_en_i;
          addr_d  = win1 ? r1_address_i : r0_address_i;
          wdata_d = win1 ? r1_write_data_i : r0_write_data_i;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (ctl_ready_i) begin
          state_d = StResp;
          if (!op_wr_q) begin
            if (owner_q[0]) rdata0_d = ctl_read_data_i;
            else            rdata1_d = ctl_read_data_i;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b0;
      owner_q  <= 2'b00;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs: controller enables only while the transaction is outstanding.
  always_comb begin
    active           = (state_q == StIssue) || (state_q == StWait);
    busy_o           = (state_q != StIdle);
    grant_o          = busy_o ? owner_q : 2'b00;
    ctl_rd_en_o      = active & ~op_wr_q;
    ctl_wr_en_o      = active & op_wr_q;
    ctl_address_o    = addr_q;
    ctl_write_data_o = wdata_q;
    r0_read_data_o   = rdata0_q;
    r1_read_data_o   = rdata1_q;
    r0_ready_o       = ~req0 | ((state_q == StResp) & owner_q[0]);
    r1_ready_o       = ~req1 | ((state_q == StResp) & owner_q[1]);
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: width of every address port.
REQ-002 Parameter DATA_W, default 32: width of every data port.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
REQ-005 r0_rd_en, r0_wr_en  in  1 each  requester 0 (data path) read/write request, level, held until r0_ready.
REQ-006 r0_address  in  ADDR_W; r0_write_data  in  DATA_W  requester 0 operands.
REQ-007 r0_read_data  out  DATA_W; r0_ready  out  1  requester 0 response/stall-release.
REQ-008 r1_rd_en, r1_wr_en, r1_address, r1_write_data, r1_read_data, r1_ready  same directions and widths as requester 0, for requester 1.
REQ-009 ctl_rd_en, ctl_wr_en  out  1; ctl_address  out  ADDR_W; ctl_write_data  out  DATA_W  to the SRAM controller.
REQ-010 ctl_read_data  in  DATA_W; ctl_ready  in  1  from the SRAM controller; ctl_ready=1 while enabled marks completion.
REQ-011 grant  out  2  one-hot owner (01=req0, 10=req1, 00=none); busy  out  1  transaction in progress.

Function
REQ-012 FSM states IDLE, ISSUE, WAIT, RESP; IDLE->ISSUE when any request is present, ISSUE->WAIT unconditionally, WAIT->RESP when ctl_ready=1, RESP->IDLE unconditionally.
REQ-013 Request of requester N = rN_rd_en | rN_wr_en; rd_en and wr_en both 1 is a write.
REQ-014 In IDLE with one request, that requester wins; with both, the one selected by the round-robin pointer wins.
REQ-015 Pointer resets to 0; on each grant it is set to the non-winning requester.
REQ-016 On the IDLE->ISSUE edge, owner, op, address and write data are latched; ctl_* are driven from the latched copies only.
REQ-017 ctl_rd_en/ctl_wr_en = 1 only in ISSUE and WAIT, per latched op; both 0 in IDLE and RESP; never both 1.
REQ-018 ctl_ready is ignored in ISSUE and IDLE.
REQ-019 On the WAIT->RESP edge, for a read, ctl_read_data is captured into the owner's read-data register; for a write, the register holds.
REQ-020 rN_read_data always shows requester N's register; the other requester's register never changes.
REQ-021 rN_ready = ~request_N | (state==RESP & owner==N), combinational.
REQ-022 Latency: request first seen in IDLE at cycle t -> ctl enable at t+1 -> ready at k+1, where k>=t+2 is the first ctl_ready cycle; minimum 3 cycles.
REQ-023 A request dropped or changed mid-transaction does not abort it; the latched transaction completes and RESP still occurs.
REQ-024 A request still present in the IDLE cycle after RESP is a new transaction (back-to-back allowed, one idle cycle minimum).
REQ-025 busy = 1 in ISSUE, WAIT, RESP; grant = owner one-hot in those states, 00 in IDLE.

Reset
REQ-026 While rst=0, independent of clk: state IDLE, pointer 0, owner cleared, ctl_rd_en=ctl_wr_en=0, ctl_address=0, ctl_write_data=0, both read-data registers 0, grant=00, busy=0, rN_ready=~request_N.
REQ-027 Reset asserted mid-transaction abandons it without RESP; operation restarts from IDLE on the first clk edge after rst=1.

Verification
REQ-028 Single read: r0_rd_en=1, addr=0x40, ctl_ready high 2 cycles after ctl_rd_en with data 0xDEADBEEF -> r0_ready low until RESP, then r0_read_data=0xDEADBEEF, grant=01 throughout.
REQ-029 Simultaneous: r0 write 0x11 @0x10 and r1 read @0x20 from reset -> req0 served first, then req1 in the next transaction; grant 01 then 10; pointer alternates on a repeat.
REQ-030 Both rd_en and wr_en from r1 @0x8, data 0x55 -> only ctl_wr_en=1; r1_read_data unchanged.
REQ-031 r0 drops rd_en while in WAIT -> ctl_rd_en stays 1 until ctl_ready; RESP occurs; captured data appears on r0_read_data.
REQ-032 rst=0 pulse while in WAIT -> ctl enables 0 and grant=00 before the next clk edge; a fresh request after release completes normally.
REQ-033 ctl_ready held at 1 during IDLE/ISSUE -> no early completion; RESP only after at least one WAIT cycle.
